bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/dock_pkg.sv | 16 +
 rtl/dock_sync2.sv | 24 ++
 rtl/bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dock_pkg.sv
// Shared types and defaults for the dock bus arbiter.
// Holds the arbiter state encoding and the default slot count.
package dock_pkg;

    localparam int NUM_SLOTS_DEFAULT = 5;
    localparam int OWNER_W           = 3;

    typedef enum logic [2:0] {
        IDLE,
        REQ_CPU,
        GRANT,
        RELEASE,
        DRAIN
    } arb_state_t;

endpackage

// File: rtl/dock_sync2.sv
// Two-flop synchronizer for asynchronous active-low bus handshake lines.
// Resets to all ones so every synchronized line reads as "inactive".
module dock_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin dock-slot bus arbiter: borrows the bus from the CPU for one slot
// at a time and always hands it back to the CPU between slot grants.
module bus_arbiter
    import dock_pkg::*;
#(
    parameter int NUM_SLOTS   = NUM_SLOTS_DEFAULT,
    parameter int HOLD_MAX    = 1024,
    parameter int TURN_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_SLOTS-1:0] slot_busreq_n,
    output logic [NUM_SLOTS-1:0] slot_busack_n,
    output logic                 cpu_busreq_n,
    input  logic                 cpu_busack_n,
    output logic [OWNER_W-1:0]   owner_slot,
    output logic                 owner_valid,
    output logic                 timeout
);

    localparam int                 HOLD_W    = $clog2(HOLD_MAX);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
    localparam logic [3:0]         TURN_LAST = 4'(TURN_CYCLES - 1);
    localparam logic [OWNER_W-1:0] LAST_SLOT = OWNER_W'(NUM_SLOTS - 1);

    logic [NUM_SLOTS-1:0] req_s;
    logic                 cpu_ack_s;

    arb_state_t           state, state_nx;
    logic [NUM_SLOTS-1:0] ack_nx;
    logic                 cpu_req_nx;
    logic [OWNER_W-1:0]   owner_nx;
    logic                 valid_nx;
    logic                 timeout_nx;
    logic [HOLD_W-1:0]    hold_cnt, hold_nx;
    logic [3:0]           turn_cnt, turn_nx;
    logic [OWNER_W-1:0]   last_owner, last_nx;
    logic                 granted, granted_nx;

    dock_sync2 #(.WIDTH(NUM_SLOTS)) u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (slot_busreq_n),
        .q     (req_s)
    );

    dock_sync2 #(.WIDTH(1)) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cpu_busack_n),
        .q     (cpu_ack_s)
    );

    // First low request found scanning upward from the slot after last_owner.
    function automatic logic [OWNER_W-1:0] rr_pick(input logic [NUM_SLOTS-1:0] req_n,
                                                   input logic [OWNER_W-1:0]   last);
        logic [OWNER_W-1:0] pick;
        logic               found;
        int                 idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_SLOTS; i++) begin
            idx = (int'(last) + i) % NUM_SLOTS;
            if (!found && !req_n[idx]) begin
                pick  = OWNER_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            slot_busack_n <= '1;
            cpu_busreq_n  <= 1'b1;
            owner_slot    <= '0;
            owner_valid   <= 1'b0;
            timeout       <= 1'b0;
            hold_cnt      <= '0;
            turn_cnt      <= '0;
            last_owner    <= LAST_SLOT;
            granted       <= 1'b0;
        end else begin
            state         <= state_nx;
            slot_busack_n <= ack_nx;
            cpu_busreq_n  <= cpu_req_nx;
            owner_slot    <= owner_nx;
            owner_valid   <= valid_nx;
            timeout       <= timeout_nx;
            hold_cnt      <= hold_nx;
            turn_cnt      <= turn_nx;
            last_owner    <= last_nx;
            granted       <= granted_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        ack_nx     = slot_busack_n;
        cpu_req_nx = cpu_busreq_n;
        owner_nx   = owner_slot;
        timeout_nx = 1'b0;
        hold_nx    = hold_cnt;
        turn_nx    = turn_cnt;
        last_nx    = last_owner;
        granted_nx = granted;

        case (state)
            IDLE: begin
                if (!(&req_s)) begin
                    owner_nx   = rr_pick(req_s, last_owner);
                    cpu_req_nx = 1'b0;
                    granted_nx = 1'b0;
                    state_nx   = REQ_CPU;
                end
            end
            REQ_CPU: begin
                if (req_s[owner_slot]) begin
                    cpu_req_nx = 1'b1;
                    state_nx   = DRAIN;
                end else if (!cpu_ack_s) begin
                    ack_nx             = '1;
                    ack_nx[owner_slot] = 1'b0;
                    hold_nx            = '0;
                    granted_nx         = 1'b1;
                    state_nx           = GRANT;
                end
            end
            GRANT: begin
                hold_nx = hold_cnt + 1'b1;
                // A voluntary release or CPU withdrawal takes precedence over the hold limit.
                if (req_s[owner_slot] || cpu_ack_s) begin
                    ack_nx   = '1;
                    turn_nx  = '0;
                    state_nx = RELEASE;
                end else if (hold_cnt == HOLD_LAST) begin
                    ack_nx     = '1;
                    timeout_nx = 1'b1;
                    turn_nx    = '0;
                    state_nx   = RELEASE;
                end
            end
            RELEASE: begin
                if (turn_cnt == TURN_LAST) begin
                    cpu_req_nx = 1'b1;
                    state_nx   = DRAIN;
                end else begin
                    turn_nx = turn_cnt + 4'd1;
                end
            end
            DRAIN: begin
                if (cpu_ack_s) begin
                    if (granted) begin
                        last_nx = owner_slot;
                    end
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        valid_nx = (state_nx == GRANT);
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and randomized bench for bus_arbiter with a round-robin set model
// and per-cycle handshake invariants.
module tb_bus_arbiter;

    localparam int N    = 5;
    localparam int HOLD = 16;
    localparam int TURN = 2;
    localparam logic [N-1:0] ALL1 = '1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] slot_busreq_n;
    logic [N-1:0] slot_busack_n;
    logic         cpu_busreq_n;
    logic         cpu_busack_n;
    logic [2:0]   owner_slot;
    logic         owner_valid;
    logic         timeout;

    always #5 clk = ~clk;

    bus_arbiter #(
        .NUM_SLOTS   (N),
        .HOLD_MAX    (HOLD),
        .TURN_CYCLES (TURN)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .slot_busreq_n (slot_busreq_n),
        .slot_busack_n (slot_busack_n),
        .cpu_busreq_n  (cpu_busreq_n),
        .cpu_busack_n  (cpu_busack_n),
        .owner_slot    (owner_slot),
        .owner_valid   (owner_valid),
        .timeout       (timeout)
    );

    int           total = 0;
    int           bad = 0;
    int           model_last;
    logic [N-1:0] rr_set;
    int           rr_active, rr_cur, rr_hold;
    int           cpu_auto, cpu_wait, cpu_released;
    int           grant_len, timeout_cnt;
    logic [N-1:0] prev_ack;
    logic         h0, h1, h2;
    int           grant_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int rr_expect();
        int s;
        for (int i = 1; i <= N; i++) begin
            s = (model_last + i) % N;
            if (rr_set[s]) return s;
        end
        return -1;
    endfunction

    task automatic tick();
        int idx;
        int new_grant;
        h2 = h1;
        h1 = h0;
        h0 = cpu_busack_n;
        @(posedge clk);
        #1;
        chk("one_ack", 32'($countones(~slot_busack_n) <= 1), 1);
        chk("ack_needs_cpu", 32'((&slot_busack_n) || !h2), 1);
        chk("valid_vs_ack", 32'(owner_valid), 32'(!(&slot_busack_n)));
        chk("owner_range", 32'(int'(owner_slot) < N), 1);
        if (!(&slot_busack_n)) chk("owner_ack", 32'(slot_busack_n[owner_slot]), 0);
        if (timeout) begin
            timeout_cnt++;
            chk("timeout_ctx", 32'({!(&prev_ack), &slot_busack_n}), 3);
            chk("timeout_len", grant_len, HOLD);
        end
        new_grant = ((&prev_ack) && !(&slot_busack_n)) ? 1 : 0;
        if (!(&slot_busack_n)) begin
            if (new_grant != 0) begin
                idx = -1;
                for (int i = 0; i < N; i++) if (!slot_busack_n[i]) idx = i;
                grant_log.push_back(idx);
                chk("cpu_between", cpu_released, 1);
                cpu_released = 0;
                grant_len = 1;
                if (rr_active != 0) begin
                    chk("rr_order", idx, rr_expect());
                    rr_cur  = idx;
                    rr_hold = int'($urandom_range(1, 24));
                end
                model_last = idx;
            end else begin
                grant_len++;
            end
        end
        if (cpu_busreq_n) cpu_released = 1;
        if (rr_active != 0 && rr_cur >= 0 && new_grant == 0) begin
            if (!slot_busack_n[rr_cur]) rr_hold--;
            if (slot_busack_n[rr_cur] || rr_hold <= 0) begin
                slot_busreq_n[rr_cur] = 1'b1;
                rr_set[rr_cur] = 1'b0;
                rr_cur = -1;
            end
        end
        prev_ack = slot_busack_n;
        if (cpu_auto != 0 && cpu_busack_n != cpu_busreq_n) begin
            if (cpu_wait <= 0) begin
                cpu_busack_n = cpu_busreq_n;
                cpu_wait = int'($urandom_range(0, 3));
            end else begin
                cpu_wait--;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        slot_busreq_n = '1;
        cpu_busack_n = 1'b1;
        repeat (3) tick();
        chk("rst_ack", 32'(slot_busack_n), 32'(ALL1));
        chk("rst_cpureq", 32'(cpu_busreq_n), 1);
        chk("rst_owner", 32'(owner_slot), 0);
        chk("rst_valid", 32'(owner_valid), 0);
        chk("rst_timeout", 32'(timeout), 0);
        rst_n = 1'b1;
        model_last = N - 1;
        cpu_released = 1;
    endtask

    task automatic wait_idle();
        int quiet = 0;
        for (int i = 0; i < 600 && quiet < 6; i++) begin
            tick();
            if ((&slot_busack_n) && cpu_busreq_n && cpu_busack_n) quiet++;
            else quiet = 0;
        end
        chk("idle_reached", 32'(quiet >= 6), 1);
    endtask

    task automatic wait_grant(output int idx);
        int n0 = grant_log.size();
        for (int i = 0; i < 400 && grant_log.size() == n0; i++) tick();
        chk("grant_seen", 32'(grant_log.size() > n0), 1);
        idx = (grant_log.size() > n0) ? grant_log[$] : -1;
    endtask

    task automatic wait_cpureq(input logic level, input string tag);
        int ok = 0;
        for (int i = 0; i < 20 && ok == 0; i++) begin
            tick();
            if (cpu_busreq_n == level) ok = 1;
        end
        chk(tag, ok, 1);
    endtask

    task automatic wait_valid(input string tag);
        int ok = 0;
        for (int i = 0; i < 100 && ok == 0; i++) begin
            tick();
            if (owner_valid) ok = 1;
        end
        chk(tag, ok, 1);
    endtask

    initial begin
        int g, n, n0, t0, done;
        int exp31[4] = '{0, 1, 4, 0};
        logic [N-1:0] mask;

        rst_n = 1'b0;
        slot_busreq_n = '1;
        cpu_busack_n = 1'b1;
        cpu_auto = 0; cpu_wait = 0; cpu_released = 1;
        rr_active = 0; rr_cur = -1; rr_hold = 0; rr_set = '0;
        grant_len = 0; timeout_cnt = 0; model_last = N - 1;
        prev_ack = '1; h0 = 1'b1; h1 = 1'b1; h2 = 1'b1;

        // Single request with exact handshake latencies
        do_reset();
        slot_busreq_n[2] = 1'b0;
        tick(); tick();
        chk("r30_req_early", 32'(cpu_busreq_n), 1);
        tick();
        chk("r30_req", 32'(cpu_busreq_n), 0);
        chk("r30_owner_pend", 32'(owner_slot), 2);
        cpu_busack_n = 1'b0;
        tick(); tick();
        chk("r30_ack_early", 32'(slot_busack_n), 32'(ALL1));
        tick();
        chk("r30_ack", 32'(slot_busack_n), 32'(5'b11011));
        chk("r30_valid", 32'(owner_valid), 1);
        chk("r30_owner", 32'(owner_slot), 2);
        slot_busreq_n[2] = 1'b1;
        tick(); tick(); tick();
        chk("r30_rel_ack", 32'(slot_busack_n), 32'(ALL1));
        chk("r30_rel_valid", 32'(owner_valid), 0);
        chk("r30_rel_timeout", 32'(timeout), 0);
        tick();
        chk("r30_turn", 32'(cpu_busreq_n), 0);
        tick();
        chk("r30_cpu_back", 32'(cpu_busreq_n), 1);
        cpu_busack_n = 1'b1;
        wait_idle();

        // Three continuous requesters rotate
        do_reset();
        cpu_auto = 1;
        n0 = grant_log.size();
        slot_busreq_n = 5'b01100;
        for (int i = 0; i < 600 && grant_log.size() < n0 + 4; i++) tick();
        slot_busreq_n = '1;
        for (int k = 0; k < 4; k++)
            chk("r31_order", (n0 + k < grant_log.size()) ? grant_log[n0 + k] : -1, exp31[k]);
        wait_idle();

        // Hold limit forces release
        do_reset();
        slot_busreq_n[3] = 1'b0;
        wait_valid("r32_grant_wait");
        chk("r32_owner", 32'(owner_slot), 3);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!owner_valid) break;
            n++;
        end
        chk("r32_len", n, HOLD);
        chk("r32_timeout", 32'(timeout), 1);
        chk("r32_ack", 32'(slot_busack_n), 32'(ALL1));
        tick();
        chk("r32_pulse_end", 32'(timeout), 0);
        chk("r32_turn", 32'(cpu_busreq_n), 0);
        tick();
        chk("r32_cpu_back", 32'(cpu_busreq_n), 1);
        slot_busreq_n = '1;
        wait_idle();

        // Withdrawal before the CPU acknowledges
        do_reset();
        cpu_auto = 0;
        n0 = grant_log.size();
        slot_busreq_n[1] = 1'b0;
        wait_cpureq(1'b0, "r33_req");
        tick(); tick();
        slot_busreq_n[1] = 1'b1;
        wait_cpureq(1'b1, "r33_req_drop");
        wait_idle();
        chk("r33_no_grant", grant_log.size(), n0);
        cpu_auto = 1;
        slot_busreq_n = 5'b11001;
        wait_grant(g);
        slot_busreq_n = '1;
        chk("r33_next_search", g, 1);
        wait_idle();

        // Asynchronous reset in the middle of a grant
        slot_busreq_n[2] = 1'b0;
        wait_valid("r34_grant_wait");
        chk("r34_owner", 32'(owner_slot), 2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("r34_async_ack", 32'(slot_busack_n), 32'(ALL1));
        chk("r34_async_cpu", 32'(cpu_busreq_n), 1);
        chk("r34_async_valid", 32'(owner_valid), 0);
        chk("r34_async_owner", 32'(owner_slot), 0);
        slot_busreq_n = '1;
        cpu_busack_n = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        model_last = N - 1;
        cpu_released = 1;
        slot_busreq_n = 5'b01110;
        wait_grant(g);
        slot_busreq_n = '1;
        chk("r34_after_reset", g, 0);
        wait_idle();

        // CPU withdraws its acknowledge during a grant
        cpu_auto = 0;
        t0 = timeout_cnt;
        slot_busreq_n[1] = 1'b0;
        wait_cpureq(1'b0, "r35_req");
        cpu_busack_n = 1'b0;
        wait_valid("r35_grant_wait");
        chk("r35_owner", 32'(owner_slot), 1);
        repeat (4) tick();
        cpu_busack_n = 1'b1;
        tick(); tick();
        chk("r35_still_valid", 32'(owner_valid), 1);
        tick();
        chk("r35_ack", 32'(slot_busack_n), 32'(ALL1));
        chk("r35_valid", 32'(owner_valid), 0);
        chk("r35_timeout", 32'(timeout), 0);
        slot_busreq_n[1] = 1'b1;
        wait_cpureq(1'b1, "r35_cpu_back");
        wait_idle();
        chk("r35_no_timeout", timeout_cnt, t0);

        // Random request sets against the round-robin model
        cpu_auto = 1;
        rr_active = 1;
        for (int r = 0; r < 25; r++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            rr_set = mask;
            rr_cur = -1;
            slot_busreq_n = ~mask;
            done = 0;
            for (int i = 0; i < 2000 && done == 0; i++) begin
                tick();
                if (rr_set == '0 && rr_cur < 0) done = 1;
            end
            chk("rr_round_done", done, 1);
            slot_busreq_n = '1;
            rr_set = '0;
            rr_cur = -1;
            wait_idle();
        end
        rr_active = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
